// File: rtl/aemb_xslu.sv
// Iterative barrel-shift / multiply unit with start/busy/ack handshake, falling-edge clocked.
// Optional high-word multiplies (MULH, MULHU) built only when AEMB_MULH_EN is defined.
module aemb_xslu #(
  parameter int unsigned DSIZ = 32,
  parameter int unsigned MULW = 2
) (
  input  logic            nclk,
  input  logic            nrst,
  input  logic            ena,
  input  logic            x_stb,
  input  logic [2:0]      x_op,
  input  logic [DSIZ-1:0] x_opa,
  input  logic [DSIZ-1:0] x_opb,
  output logic            x_busy,
  output logic            x_ack,
  output logic [DSIZ-1:0] x_res
);

  localparam int unsigned LOG  = $clog2(DSIZ);
  localparam int unsigned NMUL = DSIZ / MULW;
`ifdef AEMB_MULH_EN
  localparam int unsigned AW = 2 * DSIZ;
`else
  localparam int unsigned AW = DSIZ;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [LOG-1:0]  cnt_q, cnt_d;
  logic [LOG-1:0]  amt_q, amt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   mcd_q, mcd_d;
  logic [DSIZ-1:0] mpr_q, mpr_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic [DSIZ-1:0] res_q, res_d;
`ifdef AEMB_MULH_EN
  logic [DSIZ-1:0] opa_q, opa_d;
  logic [DSIZ-1:0] opb_q, opb_d;
  logic [DSIZ-1:0] hi_u, hi_s;
`endif

  logic [LOG-1:0]  stage_bit;
  logic [LOG-1:0]  sh_amt;
  logic [DSIZ-1:0] sh_res;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   acc_sum;
  logic [DSIZ-1:0] mul_res;

  // Datapath for the current step plus next-state selection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    amt_d   = amt_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    mpr_d   = mpr_q;
    busy_d  = busy_q;
    ack_d   = ack_q;
    res_d   = res_q;
`ifdef AEMB_MULH_EN
    opa_d   = opa_q;
    opb_d   = opb_q;
`endif

    // Shift stage cnt applies 2^cnt only when that amount bit is set.
    stage_bit = LOG'(1) << cnt_q;
    sh_amt    = amt_q & stage_bit;
    case (op_q)
      3'b000:  sh_res = acc_q[DSIZ-1:0] >> sh_amt;
      3'b001:  sh_res = DSIZ'($signed(acc_q[DSIZ-1:0]) >>> sh_amt);
      3'b010:  sh_res = acc_q[DSIZ-1:0] << sh_amt;
      default: sh_res = acc_q[DSIZ-1:0];
    endcase

    pp = '0;
    for (int j = 0; j < int'(MULW); j++) begin
      if (mpr_q[j]) pp = pp + (mcd_q << j);
    end
    acc_sum = acc_q + pp;

`ifdef AEMB_MULH_EN
    // Signed high word from the unsigned product by subtracting the sign corrections.
    hi_u = acc_sum[AW-1:DSIZ];
    hi_s = hi_u - (opa_q[DSIZ-1] ? opb_q : '0) - (opb_q[DSIZ-1] ? opa_q : '0);
`endif
    case (op_q)
      3'b011:  mul_res = acc_sum[DSIZ-1:0];
`ifdef AEMB_MULH_EN
      3'b100:  mul_res = hi_s;
      3'b101:  mul_res = hi_u;
`endif
      default: mul_res = '0;
    endcase

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (x_stb) begin
            op_d  = x_op;
            cnt_d = '0;
            amt_d = x_opb[LOG-1:0];
            acc_d = (x_op <= 3'b010) ? AW'(x_opa) : '0;
            mcd_d = AW'(x_opa);
            mpr_d = x_opb;
`ifdef AEMB_MULH_EN
            opa_d = x_opa;
            opb_d = x_opb;
`endif
            case (x_op)
              3'b000, 3'b001, 3'b010: begin
                state_d = S_SHIFT;
                busy_d  = 1'b1;
              end
`ifdef AEMB_MULH_EN
              3'b011, 3'b100, 3'b101: begin
`else
              3'b011: begin
`endif
                state_d = S_MUL;
                busy_d  = 1'b1;
              end
              default: begin
                state_d = S_DONE;
                ack_d   = 1'b1;
                res_d   = '0;
              end
            endcase
          end
        end
        S_SHIFT: begin
          acc_d = AW'(sh_res);
          cnt_d = cnt_q + LOG'(1);
          if (cnt_q == LOG'(LOG - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
            res_d   = sh_res;
          end
        end
        S_MUL: begin
          acc_d = acc_sum;
          mcd_d = mcd_q << MULW;
          mpr_d = mpr_q >> MULW;
          cnt_d = cnt_q + LOG'(1);
          if (cnt_q == LOG'(NMUL - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
            res_d   = mul_res;
          end
        end
        default: begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge nclk) begin
    if (nrst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      amt_q   <= '0;
      acc_q   <= '0;
      mcd_q   <= '0;
      mpr_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      res_q   <= '0;
`ifdef AEMB_MULH_EN
      opa_q   <= '0;
      opb_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      amt_q   <= amt_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      mpr_q   <= mpr_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
`ifdef AEMB_MULH_EN
      opa_q   <= opa_d;
      opb_q   <= opb_d;
`endif
    end
  end

  assign x_busy = busy_q;
  assign x_ack  = ack_q;
  assign x_res  = res_q;

endmodule

// File: tb/tb_aemb_xslu.sv
// Directed bench for aemb_xslu (DSIZ=32, MULW=2); DUT updates on falling edges,
// stimulus is driven and outputs are sampled on rising edges.
module tb_aemb_xslu;

  logic        nclk;
  logic        nrst;
  logic        ena;
  logic        x_stb;
  logic [2:0]  x_op;
  logic [31:0] x_opa;
  logic [31:0] x_opb;
  logic        x_busy;
  logic        x_ack;
  logic [31:0] x_res;

  int n_vec = 0;
  int n_err = 0;

  aemb_xslu #(.DSIZ(32), .MULW(2)) dut (
    .nclk  (nclk),
    .nrst  (nrst),
    .ena   (ena),
    .x_stb (x_stb),
    .x_op  (x_op),
    .x_opa (x_opa),
    .x_opb (x_opb),
    .x_busy(x_busy),
    .x_ack (x_ack),
    .x_res (x_res)
  );

  initial begin
    nclk = 1'b1;
    forever #5 nclk = ~nclk;
  end

  // Issue one op and run until ack (bounded); returns latency, busy cycles, result, ack next cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt, output logic [31:0] res,
                       output logic ack_after);
    @(posedge nclk);
    x_stb = 1'b1; x_op = op; x_opa = a; x_opb = b;
    @(posedge nclk);
    x_stb = 1'b0;
    lat = 1; bcnt = 0;
    while (x_ack !== 1'b1 && lat < 100) begin
      if (x_busy === 1'b1) bcnt++;
      @(posedge nclk);
      lat++;
    end
    res = x_res;
    @(posedge nclk);
    ack_after = x_ack;
  endtask

  task automatic test_reset();
    nrst = 1'b1; ena = 1'b1; x_stb = 1'b0; x_op = '0; x_opa = '0; x_opb = '0;
    repeat (2) @(posedge nclk);
    n_vec++; if (x_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", x_busy); end
    n_vec++; if (x_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", x_ack); end
    n_vec++; if (x_res !== 32'h0) begin n_err++; $display("FAIL reset_res: got %h expected 0", x_res); end
    nrst = 1'b0;
  endtask

  task automatic test_shift();
    logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2};
    logic [31:0] as  [6] = '{32'h80000010, 32'h1, 32'h1234, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [6] = '{32'h4, 32'h25, 32'h0, 32'h1F, 32'h1F, 32'h20};
    logic [31:0] exp [6] = '{32'hF8000001, 32'h20, 32'h1234, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    int lat, bc; logic [31:0] r; logic aa;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], lat, bc, r, aa);
      n_vec++; if (r !== exp[i]) begin n_err++; $display("FAIL shift%0d_res: got %h expected %h", i, r, exp[i]); end
      n_vec++; if (lat != 6) begin n_err++; $display("FAIL shift%0d_lat: got %0d expected 6", i, lat); end
      n_vec++; if (bc != 5) begin n_err++; $display("FAIL shift%0d_busy: got %0d expected 5", i, bc); end
      n_vec++; if (aa !== 1'b0) begin n_err++; $display("FAIL shift%0d_ackpulse: got %b expected 0", i, aa); end
    end
    n_vec++; if (x_res !== 32'hFFFFFFFF) begin n_err++; $display("FAIL shift_hold: got %h expected ffffffff", x_res); end
  endtask

  task automatic test_mul();
    logic [31:0] as  [4] = '{32'hFFFFFFFF, 32'h10000, 32'h12345678, 32'h7};
    logic [31:0] bs  [4] = '{32'hFFFFFFFF, 32'h10000, 32'h9, 32'h6};
    logic [31:0] exp [4] = '{32'h1, 32'h0, 32'hA3D70A38, 32'h2A};
    int lat, bc; logic [31:0] r; logic aa;
    for (int i = 0; i < 4; i++) begin
      do_op(3'd3, as[i], bs[i], lat, bc, r, aa);
      n_vec++; if (r !== exp[i]) begin n_err++; $display("FAIL mul%0d_res: got %h expected %h", i, r, exp[i]); end
      n_vec++; if (lat != 17) begin n_err++; $display("FAIL mul%0d_lat: got %0d expected 17", i, lat); end
      n_vec++; if (aa !== 1'b0) begin n_err++; $display("FAIL mul%0d_ackpulse: got %b expected 0", i, aa); end
    end
  endtask

  task automatic test_mulh();
`ifdef AEMB_MULH_EN
    logic [2:0]  ops [3] = '{3'd5, 3'd4, 3'd4};
    logic [31:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2};
    logic [31:0] exp [3] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF};
    int          el  = 17;
`else
    logic [2:0]  ops [3] = '{3'd5, 3'd4, 3'd4};
    logic [31:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2};
    logic [31:0] exp [3] = '{32'h0, 32'h0, 32'h0};
    int          el  = 1;
`endif
    int lat, bc; logic [31:0] r; logic aa;
    for (int i = 0; i < 3; i++) begin
      // Seed a nonzero result so a zero expectation is meaningful.
      do_op(3'd3, 32'h3, 32'h5, lat, bc, r, aa);
      do_op(ops[i], as[i], bs[i], lat, bc, r, aa);
      n_vec++; if (r !== exp[i]) begin n_err++; $display("FAIL mulh%0d_res: got %h expected %h", i, r, exp[i]); end
      n_vec++; if (lat != el) begin n_err++; $display("FAIL mulh%0d_lat: got %0d expected %0d", i, lat, el); end
    end
  endtask

  task automatic test_illegal();
    int lat, bc; logic [31:0] r; logic aa;
    for (int op = 6; op < 8; op++) begin
      do_op(3'd2, 32'h1, 32'h3, lat, bc, r, aa);
      do_op(3'(op), 32'hDEADBEEF, 32'h5, lat, bc, r, aa);
      n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL illegal%0d_res: got %h expected 0", op, r); end
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL illegal%0d_lat: got %0d expected 1", op, lat); end
      n_vec++; if (aa !== 1'b0) begin n_err++; $display("FAIL illegal%0d_ackpulse: got %b expected 0", op, aa); end
    end
  endtask

  task automatic test_ena_stall();
    int lat;
    @(posedge nclk);
    x_stb = 1'b1; x_op = 3'd3; x_opa = 32'h7; x_opb = 32'h6;
    @(posedge nclk);
    x_stb = 1'b0;
    repeat (4) @(posedge nclk);
    // Cycles 5..7 frozen, with a stray strobe that must not be queued.
    ena = 1'b0; x_stb = 1'b1; x_op = 3'd2; x_opa = 32'h1; x_opb = 32'h1;
    repeat (3) @(posedge nclk);
    n_vec++; if (x_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b expected 1", x_busy); end
    ena = 1'b1; x_stb = 1'b0;
    lat = 8;
    while (x_ack !== 1'b1 && lat < 100) begin @(posedge nclk); lat++; end
    n_vec++; if (lat != 20) begin n_err++; $display("FAIL stall_lat: got %0d expected 20", lat); end
    n_vec++; if (x_res !== 32'h2A) begin n_err++; $display("FAIL stall_res: got %h expected 0000002a", x_res); end
    repeat (2) @(posedge nclk);
    n_vec++; if (x_busy !== 1'b0 || x_ack !== 1'b0) begin
      n_err++; $display("FAIL stall_noqueue: got busy=%b ack=%b expected 0 0", x_busy, x_ack);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [31:0] r; logic aa;
    @(posedge nclk);
    x_stb = 1'b1; x_op = 3'd6; x_opa = '0; x_opb = '0;
    @(posedge nclk);
    x_stb = 1'b0;
    n_vec++; if (x_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack: got %b expected 1", x_ack); end
    ena = 1'b0;
    @(posedge nclk);
    n_vec++; if (x_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ackfrozen: got %b expected 1", x_ack); end
    // Strobe presented while still in DONE is ignored; the following cycle accepts it.
    ena = 1'b1; x_stb = 1'b1; x_op = 3'd2; x_opa = 32'h1; x_opb = 32'h1;
    @(posedge nclk);
    n_vec++; if (x_busy !== 1'b0 || x_ack !== 1'b0) begin
      n_err++; $display("FAIL b2b_done_ignore: got busy=%b ack=%b expected 0 0", x_busy, x_ack);
    end
    @(posedge nclk);
    x_stb = 1'b0;
    n_vec++; if (x_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b expected 1", x_busy); end
    lat = 1;
    while (x_ack !== 1'b1 && lat < 100) begin @(posedge nclk); lat++; end
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL b2b_lat: got %0d expected 6", lat); end
    n_vec++; if (x_res !== 32'h2) begin n_err++; $display("FAIL b2b_res: got %h expected 00000002", x_res); end
    do_op(3'd3, 32'h3, 32'h5, lat, bc, r, aa);
  endtask

  task automatic test_abort();
    int lat, bc, acks; logic [31:0] r; logic aa;
    @(posedge nclk);
    x_stb = 1'b1; x_op = 3'd3; x_opa = 32'h11; x_opb = 32'h3;
    @(posedge nclk);
    x_stb = 1'b0;
    repeat (7) @(posedge nclk);
    nrst = 1'b1;
    @(posedge nclk);
    nrst = 1'b0;
    n_vec++; if (x_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", x_busy); end
    n_vec++; if (x_res !== 32'h0) begin n_err++; $display("FAIL abort_res: got %h expected 0", x_res); end
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (x_ack === 1'b1) acks++;
      @(posedge nclk);
    end
    n_vec++; if (acks != 0) begin n_err++; $display("FAIL abort_noack: got %0d acks expected 0", acks); end
    do_op(3'd2, 32'h3, 32'h4, lat, bc, r, aa);
    n_vec++; if (r !== 32'h30) begin n_err++; $display("FAIL abort_next_res: got %h expected 00000030", r); end
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL abort_next_lat: got %0d expected 6", lat); end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_mul();
    test_mulh();
    test_illegal();
    test_ena_stall();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
